// File: rtl/instr_mem_sync_if.sv
// Fetch/program-write bus of instr_mem_sync.
// master = PC/fetch logic or loader, slave = the memory.
interface instr_mem_sync_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              fetch_en;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] RD;
   logic              rd_valid;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              busy;
   logic              wr_err;

   modport master (
      output fetch_en, A, we, wa, wd,
      input  RD, rd_valid, busy, wr_err
   );

   modport slave (
      input  fetch_en, A, we, wa, wd,
      output RD, rd_valid, busy, wr_err
   );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction RAM with a post-reset boot walk and a run-time load port.
// Define INSTR_MEM_DEFAULT_PROG_EN to boot the built-in test program into words 0-6.
module instr_mem_sync #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input logic           clk,
   input logic           rst,
   instr_mem_sync_if.slave bus
);
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {BOOT, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic              rd_valid_q;
   logic              wr_err_q;

   logic              a_ok;
   logic              wa_ok;
   logic [DATA_W-1:0] boot_wd;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wd;

   assign a_ok  = {1'b0, bus.A}  < DEPTH_L;
   assign wa_ok = {1'b0, bus.wa} < DEPTH_L;

`ifdef INSTR_MEM_DEFAULT_PROG_EN
   always_comb begin
      boot_wd = '0;
      case (ptr)
         ADDR_W'(0): boot_wd = DATA_W'(32'h2001_0003);
         ADDR_W'(1): boot_wd = DATA_W'(32'h2002_0009);
         ADDR_W'(2): boot_wd = DATA_W'(32'h0022_1020);
         ADDR_W'(3): boot_wd = DATA_W'(32'h0022_1824);
         ADDR_W'(4): boot_wd = DATA_W'(32'h0022_2025);
         ADDR_W'(5): boot_wd = DATA_W'(32'h0022_2827);
         ADDR_W'(6): boot_wd = DATA_W'(32'h00A4_302A);
         default:    boot_wd = '0;
      endcase
   end
`else
   assign boot_wd = '0;
`endif

   // Single RAM write port shared by the boot walk and the load port; nothing is written while rst is high.
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = bus.wa[IDX_W-1:0];
      mem_wd  = bus.wd;
      if (!rst) begin
         if (state == BOOT) begin
            mem_we  = 1'b1;
            mem_idx = ptr[IDX_W-1:0];
            mem_wd  = boot_wd;
         end else if (bus.we && wa_ok) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wd;
      end
   end

   // RD samples mem with the pre-edge value, so a same-edge write to A is read-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         ptr        <= '0;
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
         case (state)
            BOOT: begin
               if (ptr == LAST) begin
                  state <= RUN;
               end else begin
                  ptr <= ptr + 1'b1;
               end
               if (bus.we) begin
                  wr_err_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.fetch_en) begin
                  rd_valid_q <= 1'b1;
                  rd_q       <= a_ok ? mem[bus.A[IDX_W-1:0]] : '0;
               end
               if (bus.we && !wa_ok) begin
                  wr_err_q <= 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   assign bus.RD       = rd_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = (state == BOOT);
   assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: a DEPTH=256 instance and a DEPTH=16 instance.
// Expected program words follow INSTR_MEM_DEFAULT_PROG_EN when it is defined.
module tb_instr_mem_sync;
   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic [31:0] prog [8];

   always #5 clk = ~clk;

   instr_mem_sync_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
   instr_mem_sync_if #(.ADDR_W(8), .DATA_W(32)) b1 ();

   instr_mem_sync #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) u0 (
      .clk (clk),
      .rst (rst0),
      .bus (b0)
   );

   instr_mem_sync #(.ADDR_W(8), .DATA_W(32), .DEPTH(16)) u1 (
      .clk (clk),
      .rst (rst1),
      .bus (b1)
   );

   task automatic tick;
      @(negedge clk);
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef INSTR_MEM_DEFAULT_PROG_EN
      prog[0] = 32'h2001_0003; prog[1] = 32'h2002_0009;
      prog[2] = 32'h0022_1020; prog[3] = 32'h0022_1824;
      prog[4] = 32'h0022_2025; prog[5] = 32'h0022_2827;
      prog[6] = 32'h00A4_302A; prog[7] = 32'h0000_0000;
`else
      for (int i = 0; i < 8; i++) prog[i] = '0;
`endif
      rst0 = 1'b1; rst1 = 1'b1;
      b0.fetch_en = 1'b0; b0.A = '0; b0.we = 1'b0; b0.wa = '0; b0.wd = '0;
      b1.fetch_en = 1'b0; b1.A = '0; b1.we = 1'b0; b1.wa = '0; b1.wd = '0;
      tick; tick;
      check("rst_rd",       b0.RD,       32'h0);
      check("rst_rd_valid", b0.rd_valid, 32'h0);
      check("rst_busy",     b0.busy,     32'h1);
      check("rst_wr_err",   b0.wr_err,   32'h0);
      check("rst_busy16",   b1.busy,     32'h1);

      rst0 = 1'b0; rst1 = 1'b0; cyc = 0;
      tick; tick;
      // write and fetch attempts at boot edge 3 on both instances
      b0.we = 1'b1; b0.wa = 8'd0; b0.wd = 32'hFFFF_FFFF; b0.fetch_en = 1'b1; b0.A = 8'd0;
      b1.we = 1'b1; b1.wa = 8'd0; b1.wd = 32'hFFFF_FFFF; b1.fetch_en = 1'b1; b1.A = 8'd0;
      tick;
      check("boot_wr_err",   b0.wr_err,   32'h1);
      check("boot_rd_valid", b0.rd_valid, 32'h0);
      check("boot_busy",     b0.busy,     32'h1);
      check("boot_wr_err16", b1.wr_err,   32'h1);
      b0.we = 1'b0; b0.fetch_en = 1'b0;
      b1.we = 1'b0; b1.fetch_en = 1'b0;
      tick;
      check("boot_wr_err_end", b0.wr_err, 32'h0);
      while (cyc < 15) tick;
      check("busy16_last", b1.busy, 32'h1);
      tick;
      check("busy16_done", b1.busy, 32'h0);

      // DEPTH=16 instance in RUN
      b1.fetch_en = 1'b1; b1.A = 8'd0;
      tick;
      check("d16_a0_rd",    b1.RD,       prog[0]);
      check("d16_a0_valid", b1.rd_valid, 32'h1);
      b1.A = 8'd20;
      tick;
      check("d16_a20_rd",    b1.RD,       32'h0);
      check("d16_a20_valid", b1.rd_valid, 32'h1);
      b1.A = 8'd3;
      tick;
      check("d16_a3_rd", b1.RD, prog[3]);
      b1.fetch_en = 1'b0;
      tick;
      check("d16_idle_valid", b1.rd_valid, 32'h0);
      check("d16_idle_hold",  b1.RD,       prog[3]);
      b1.we = 1'b1; b1.wa = 8'd20; b1.wd = 32'h1234_5678;
      tick;
      check("d16_wa20_err", b1.wr_err, 32'h1);
      b1.we = 1'b0;
      tick;
      check("d16_wa20_err_end", b1.wr_err, 32'h0);
      b1.we = 1'b1; b1.wa = 8'd16; b1.wd = 32'h5555_AAAA;
      tick;
      check("d16_wa16_err", b1.wr_err, 32'h1);
      b1.wa = 8'd15; b1.wd = 32'hCAFE_F00D;
      tick;
      check("d16_wa15_err", b1.wr_err, 32'h0);
      b1.we = 1'b0; b1.fetch_en = 1'b1; b1.A = 8'd4;
      tick;
      check("d16_a4_rd", b1.RD, prog[4]);
      b1.A = 8'd15;
      tick;
      check("d16_a15_rd", b1.RD, 32'hCAFE_F00D);
      b1.A = 8'd16;
      tick;
      check("d16_a16_rd",    b1.RD,       32'h0);
      check("d16_a16_valid", b1.rd_valid, 32'h1);
      b1.fetch_en = 1'b0;

      // one-cycle reset of the DEPTH=256 instance at boot cycle 100
      while (cyc < 99) tick;
      check("pre_rst_busy", b0.busy, 32'h1);
      rst0 = 1'b1;
      tick;
      check("midboot_rst_busy",  b0.busy,     32'h1);
      check("midboot_rst_rd",    b0.RD,       32'h0);
      check("midboot_rst_valid", b0.rd_valid, 32'h0);
      rst0 = 1'b0;
      for (int i = 0; i < 255; i++) tick;
      check("reboot_busy_255", b0.busy, 32'h1);
      tick;
      check("reboot_busy_256", b0.busy, 32'h0);

      // back-to-back fetches A=0..7
      b0.fetch_en = 1'b1; b0.A = 8'd0;
      tick;
      for (int i = 1; i < 8; i++) begin
         check($sformatf("b2b_rd_%0d", i - 1), b0.RD, prog[i-1]);
         check($sformatf("b2b_valid_%0d", i - 1), b0.rd_valid, 32'h1);
         b0.A = 8'(i);
         tick;
      end
      check("b2b_rd_7",    b0.RD,       prog[7]);
      check("b2b_valid_7", b0.rd_valid, 32'h1);

      // read-first on a same-edge fetch and write to A=5
      b0.A = 8'd5; b0.we = 1'b1; b0.wa = 8'd5; b0.wd = 32'hDEAD_BEEF;
      tick;
      check("rf_old_word", b0.RD,     prog[5]);
      check("rf_wr_err",   b0.wr_err, 32'h0);
      b0.we = 1'b0;
      tick;
      check("rf_new_word", b0.RD, 32'hDEAD_BEEF);
      b0.fetch_en = 1'b0;
      tick;
      check("idle_valid", b0.rd_valid, 32'h0);
      check("idle_hold",  b0.RD,       32'hDEAD_BEEF);

      // reset while in RUN and fetching
      b0.fetch_en = 1'b1; b0.A = 8'd5;
      rst0 = 1'b1;
      tick;
      check("run_rst_rd",    b0.RD,       32'h0);
      check("run_rst_valid", b0.rd_valid, 32'h0);
      check("run_rst_busy",  b0.busy,     32'h1);
      rst0 = 1'b0; b0.fetch_en = 1'b0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the single-cycle/multicycle MIPS datapath. It replaces the fixed combinational program ROM with a RAM that self-initialises after reset through a boot sequencer. It serves registered instruction fetches with a valid strobe and accepts run-time program writes through a load port. It sits between the PC/fetch logic and the decode stage; the load port is driven by the board loader or by the testbench.

## Interface
- ADDR_W, 8, width of the fetch and write address.
- DATA_W, 32, instruction word width.
- DEPTH, 256, number of stored words. Legal range: 7 ≤ DEPTH ≤ 2^ADDR_W.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- fetch_en  in  1  fetch request for address A.
- A  in  ADDR_W  fetch address (word index).
- RD  out  DATA_W  fetched instruction; registered.
- rd_valid  out  1  RD was updated by the fetch accepted on the previous edge.
- we  in  1  program-write request.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- busy  out  1  boot sequence in progress; fetches and writes are not accepted.
- wr_err  out  1  one-cycle pulse: the write on the previous edge was dropped.

## Operation
- States:
  - BOOT: pointer ptr walks 0..DEPTH-1, writing one word per cycle.
  - RUN: normal operation.
- rst=1 forces BOOT with ptr=0, regardless of the current state (including mid-boot and mid-fetch).
- BOOT write value at ptr is the default-program word or 0, as defined under Configuration.
- BOOT → RUN on the edge that writes ptr=DEPTH-1.
- busy=1 exactly while in BOOT.
- Fetch is accepted when state=RUN and fetch_en=1:
  - A < DEPTH: RD ← mem[A].
  - A ≥ DEPTH: RD ← 0.
  - rd_valid ← 1 in both cases.
- Without an accepted fetch, rd_valid ← 0 and RD holds its value.
- Write is accepted when state=RUN, we=1 and wa < DEPTH: mem[wa] ← wd.
- Dropped writes: a write with we=1 during BOOT, or with wa ≥ DEPTH, is discarded and wr_err ← 1 on the next edge. Otherwise wr_err ← 0.
- Same edge fetch and write to the same address are read-first: RD gets the old word, and the new word is visible from the next fetch.
- Fetch and write are independent; both may be accepted on the same edge.
- Addresses are never wrapped; out-of-range is handled as above.

## Timing
- Reset values:
  - RD=0, rd_valid=0, busy=1, wr_err=0, ptr=0.
  - Memory contents are undefined until the boot sequence completes.
- Boot length: busy stays high for exactly DEPTH cycles after the first edge with rst=0, then drops.
- Fetch latency: request sampled at edge n; RD and rd_valid are valid after edge n, i.e. during cycle n+1.
- Back-to-back fetches: one per cycle, rd_valid held high continuously.
- Write latency: a write at edge n is readable by a fetch sampled at edge n+1.
- wr_err is a single-cycle pulse per dropped write, aligned like rd_valid.
- Reset asserted mid-boot restarts the walk at ptr=0; the full DEPTH-cycle boot applies again.

## Configuration
- Macro INSTR_MEM_DEFAULT_PROG_EN.
- Defined: BOOT writes the default test program into words 0–6 and 0 into every other word. Program words:
  - 0: 0x20010003 (addi $1,$0,3)
  - 1: 0x20020009 (addi $2,$0,9)
  - 2: 0x00221020 (add $2,$1,$2)
  - 3: 0x00221824 (and $3,$1,$2)
  - 4: 0x00222025 (or $4,$1,$2)
  - 5: 0x00222827 (nor $5,$1,$2)
  - 6: 0x00A4302A (slt $6,$5,$4)
- Undefined: BOOT writes 0 to every word. Boot length is identical (DEPTH cycles).

## Test plan
- Reset, then default params with macro defined → busy high 256 cycles after rst release. Fetch A=0..7 back-to-back → RD = 0x20010003, 0x20020009, 0x00221020, 0x00221824, 0x00222025, 0x00222827, 0x00A4302A, 0x00000000, each one cycle after its request, rd_valid continuously 1.
- Macro undefined → fetch A=0 after boot returns 0x00000000 with rd_valid=1.
- Write wa=5, wd=0xDEADBEEF while fetching A=5 on the same edge → RD=0x00222827. Fetch A=5 next cycle → RD=0xDEADBEEF.
- DEPTH=16, ADDR_W=8:
  - Fetch A=20 → RD=0, rd_valid=1.
  - Write wa=20 → wr_err pulses 1 cycle; a fetch of A=4 afterwards is unchanged.
- we=1 during boot at cycle 3 → wr_err=1 for one cycle, rd_valid stays 0, and the boot contents are unaffected.
- Assert rst at boot cycle 100 for one cycle → busy stays high; RUN is reached exactly DEPTH cycles after the rst release; RD=0 and rd_valid=0 during reset.
